// File: rtl/pcie_dma_tx_ram_rd_ctrl.sv
// pcie_dma_tx_ram_rd_ctrl
//   Fetches TLP payload beats (128-bit words) from the TX data RAM and
//   presents them one beat at a time to the MWr TLP generator. It keeps an
//   output register plus a 2-entry prefetch buffer, so continuous
//   consumption runs at one beat per cycle.
//
// Optional feature: define PCIE_DMA_TX_RD_DBG_EN to add the TLP and beat
//   debug counters o_dbg_tlp_cnt / o_dbg_beat_cnt.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_rd_en          payload read request (accepted in IDLE)
//   i_rd_length      payload length in DW (0 = 1024 DW)
//   i_mwr_tlp_tx     consumer is in its data phase
//   i_mwr_tx_hold    consumer back-pressure
//   i_tx_restart     synchronous restart: back to IDLE, address 0
//   o_ram_rd_en      RAM read strobe
//   o_ram_rd_addr    RAM word address
//   i_ram_rd_data    RAM data, valid one cycle after o_ram_rd_en
//   o_gen_tlp_start  payload beat valid
//   o_rd_data        current payload beat
//   o_last_data      current beat is the final beat of the TLP
//
// state  | meaning
// IDLE   | waiting for i_rd_en; the first read is issued on acceptance
// FILL   | reads in flight, output register still empty
// STREAM | presenting beats, prefetching the rest
// DONE   | final beat consumed, waiting for i_rd_en to drop
module pcie_dma_tx_ram_rd_ctrl #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_en,
  input  logic [9:0]            i_rd_length,
  input  logic                  i_mwr_tlp_tx,
  input  logic                  i_mwr_tx_hold,
  input  logic                  i_tx_restart,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  input  logic [127:0]          i_ram_rd_data,
  output logic                  o_gen_tlp_start,
  output logic [127:0]          o_rd_data,
  output logic                  o_last_data
`ifdef PCIE_DMA_TX_RD_DBG_EN
  ,
  output logic [15:0]           o_dbg_tlp_cnt,
  output logic [23:0]           o_dbg_beat_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            r_state;
  logic [10:0]           r_req_left;   // beats not yet requested from RAM
  logic [10:0]           r_cons_left;  // beats not yet consumed
  logic                  r_ram_rd_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_dvld;       // i_ram_rd_data valid this cycle
  logic                  r_out_vld;
  logic [127:0]          r_out_data;
  logic [127:0]          r_buf0;
  logic [127:0]          r_buf1;
  logic [1:0]            r_buf_cnt;

  logic [10:0] w_len11;
  logic [10:0] w_beats;
  logic        w_consume;
  logic        w_last_consume;
  logic [2:0]  w_occ;
  logic        w_issue;
  logic        w_out_free;
  logic        w_pop;
  logic        w_push;

  assign w_len11        = (i_rd_length == 10'd0) ? 11'd1024 : {1'b0, i_rd_length};
  assign w_beats        = (w_len11 + 11'd3) >> 2;
  assign w_consume      = r_out_vld & i_mwr_tlp_tx & ~i_mwr_tx_hold;
  assign w_last_consume = w_consume & (r_cons_left == 11'd1);

  // Slots in use after this cycle's consume: output reg, buffer and the two
  // pipeline stages of in-flight reads. Three slots exist in total.
  assign w_occ = {2'b00, r_out_vld} + {1'b0, r_buf_cnt} + {2'b00, r_ram_rd_en}
               + {2'b00, r_dvld} - {2'b00, w_consume};

  // The first read goes out on acceptance to reach the 3-cycle first-beat latency.
  assign w_issue = ((r_state == S_IDLE) & i_rd_en)
                 | (((r_state == S_FILL) | (r_state == S_STREAM))
                    & (r_req_left != 11'd0) & (w_occ < 3'd3));

  assign w_out_free = ~r_out_vld | w_consume;
  assign w_pop      = w_out_free & (r_buf_cnt != 2'd0);
  assign w_push     = r_dvld & ~(w_out_free & (r_buf_cnt == 2'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_left  <= '0;
      r_cons_left <= '0;
      r_ram_rd_en <= 1'b0;
      r_addr      <= '0;
      r_dvld      <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_buf_cnt   <= '0;
    end else if (i_tx_restart) begin
      r_state     <= S_IDLE;
      r_req_left  <= '0;
      r_cons_left <= '0;
      r_ram_rd_en <= 1'b0;
      r_addr      <= '0;
      r_dvld      <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_buf_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (i_rd_en) r_state <= S_FILL;
        S_FILL:   if (r_dvld) r_state <= S_STREAM;
        S_STREAM: if (w_last_consume) r_state <= S_DONE;
        default:  if (!i_rd_en) r_state <= S_IDLE;
      endcase

      if (r_state == S_IDLE) begin
        if (i_rd_en) begin
          r_req_left  <= w_beats - 11'd1;
          r_cons_left <= w_beats;
        end
      end else begin
        if (w_issue)   r_req_left  <= r_req_left - 11'd1;
        if (w_consume) r_cons_left <= r_cons_left - 11'd1;
      end

      r_ram_rd_en <= w_issue;
      r_dvld      <= r_ram_rd_en;
      if (r_ram_rd_en) r_addr <= r_addr + ADDR_WIDTH'(1);

      if (w_out_free) begin
        if (r_buf_cnt != 2'd0) begin
          r_out_vld  <= 1'b1;
          r_out_data <= r_buf0;
        end else if (r_dvld) begin
          r_out_vld  <= 1'b1;
          r_out_data <= i_ram_rd_data;
        end else begin
          r_out_vld  <= 1'b0;
        end
      end

      case ({w_pop, w_push})
        2'b11: begin
          if (r_buf_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_ram_rd_data;
          end else begin
            r_buf0 <= i_ram_rd_data;
          end
        end
        2'b10: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b01: begin
          if (r_buf_cnt == 2'd0) r_buf0 <= i_ram_rd_data;
          else                   r_buf1 <= i_ram_rd_data;
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_ram_rd_en     = r_ram_rd_en;
  assign o_ram_rd_addr   = r_addr;
  assign o_gen_tlp_start = r_out_vld;
  assign o_rd_data       = r_out_data;
  assign o_last_data     = r_out_vld & (r_cons_left == 11'd1);

`ifdef PCIE_DMA_TX_RD_DBG_EN
  logic [15:0] r_dbg_tlp_cnt;
  logic [23:0] r_dbg_beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbg_tlp_cnt  <= '0;
      r_dbg_beat_cnt <= '0;
    end else if (i_tx_restart) begin
      r_dbg_tlp_cnt  <= '0;
      r_dbg_beat_cnt <= '0;
    end else begin
      if (w_last_consume) r_dbg_tlp_cnt  <= r_dbg_tlp_cnt + 16'd1;
      if (w_consume)      r_dbg_beat_cnt <= r_dbg_beat_cnt + 24'd1;
    end
  end

  assign o_dbg_tlp_cnt  = r_dbg_tlp_cnt;
  assign o_dbg_beat_cnt = r_dbg_beat_cnt;
`endif

endmodule

// File: tb/tb_pcie_dma_tx_ram_rd_ctrl.sv
// Bench for pcie_dma_tx_ram_rd_ctrl, built with ADDR_WIDTH=3 so address
// wrap is reached quickly. The RAM model returns a fixed word per address.
module tb_pcie_dma_tx_ram_rd_ctrl;

  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          i_rd_en;
  logic [9:0]    i_rd_length;
  logic          i_mwr_tlp_tx;
  logic          i_mwr_tx_hold;
  logic          i_tx_restart;
  logic          o_ram_rd_en;
  logic [AW-1:0] o_ram_rd_addr;
  logic [127:0]  i_ram_rd_data;
  logic          o_gen_tlp_start;
  logic [127:0]  o_rd_data;
  logic          o_last_data;
`ifdef PCIE_DMA_TX_RD_DBG_EN
  logic [15:0]   o_dbg_tlp_cnt;
  logic [23:0]   o_dbg_beat_cnt;
`endif

  pcie_dma_tx_ram_rd_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rd_en         (i_rd_en),
    .i_rd_length     (i_rd_length),
    .i_mwr_tlp_tx    (i_mwr_tlp_tx),
    .i_mwr_tx_hold   (i_mwr_tx_hold),
    .i_tx_restart    (i_tx_restart),
    .o_ram_rd_en     (o_ram_rd_en),
    .o_ram_rd_addr   (o_ram_rd_addr),
    .i_ram_rd_data   (i_ram_rd_data),
    .o_gen_tlp_start (o_gen_tlp_start),
    .o_rd_data       (o_rd_data),
    .o_last_data     (o_last_data)
`ifdef PCIE_DMA_TX_RD_DBG_EN
    ,
    .o_dbg_tlp_cnt   (o_dbg_tlp_cnt),
    .o_dbg_beat_cnt  (o_dbg_beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] word(input logic [AW-1:0] a);
    logic [127:0] k;
    k = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    return k ^ {4{29'd0, a}} ^ {a, 125'd0};
  endfunction

  // RAM: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk)
    i_ram_rd_data <= o_ram_rd_en ? word(o_ram_rd_addr) : 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  int n_tot;
  int n_pass;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  bit            mon_en;
  logic [AW-1:0] exp_rd_addr;
  int            rd_cnt;

  always @(posedge clk) begin
    if (mon_en && o_ram_rd_en) begin
      chk("rd_addr", 128'(o_ram_rd_addr), 128'(exp_rd_addr));
      exp_rd_addr = exp_rd_addr + 3'd1;
      rd_cnt++;
    end
  end

  typedef struct {
    logic [9:0]    len;
    int            beats;
    logic [AW-1:0] addr;
    int            hold_beat;
    int            hold_cyc;
    bit            use_tx;
    bit            keep_en;
  } vec_t;

  task automatic run_tlp(input vec_t v);
    bit            early;
    bit            hold;
    int            beat;
    int            held;
    int            cyc;
    logic [AW-1:0] a;
    exp_rd_addr = v.addr;
    rd_cnt = 0;
    mon_en = 1'b1;
    @(negedge clk);
    i_rd_length = v.len;
    i_rd_en = 1'b1;
    i_mwr_tlp_tx = 1'b1;
    i_mwr_tx_hold = 1'b0;
    early = 1'b0;
    @(posedge clk); #1;
    if (o_gen_tlp_start) early = 1'b1;
    if (!v.keep_en) i_rd_en = 1'b0;
    @(posedge clk); #1;
    if (o_gen_tlp_start) early = 1'b1;
    @(posedge clk); #1;
    chk("latency", {early, o_gen_tlp_start}, 2'b01);
    beat = 0;
    held = 0;
    cyc = 0;
    while (beat < v.beats && cyc < v.beats + v.hold_cyc + 8) begin
      a = v.addr + AW'(beat);
      chk("valid", o_gen_tlp_start, 1'b1);
      chk("data", o_rd_data, word(a));
      chk("last", o_last_data, (beat == v.beats - 1));
      hold = (beat == v.hold_beat) && (held < v.hold_cyc);
      if (hold) held++;
      if (v.use_tx) i_mwr_tlp_tx = ~hold;
      else          i_mwr_tx_hold = hold;
      @(posedge clk); #1;
      cyc++;
      if (!hold) beat++;
    end
    chk("beats_done", beat, v.beats);
    i_mwr_tx_hold = 1'b0;
    i_mwr_tlp_tx = 1'b1;
    chk("end_start", o_gen_tlp_start, 1'b0);
    chk("end_last", o_last_data, 1'b0);
    if (v.keep_en) begin
      early = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        if (o_gen_tlp_start) early = 1'b1;
      end
      chk("done_hold", early, 1'b0);
      i_rd_en = 1'b0;
    end
    @(posedge clk); #1;
    chk("rd_count", rd_cnt, v.beats);
  endtask

  vec_t vt[9];
  vec_t vx;
  bit   bad;

  initial begin
    n_tot = 0;
    n_pass = 0;
    mon_en = 1'b0;
    exp_rd_addr = '0;
    rd_cnt = 0;
    rst_n = 1'b0;
    i_rd_en = 1'b0;
    i_rd_length = '0;
    i_mwr_tlp_tx = 1'b0;
    i_mwr_tx_hold = 1'b0;
    i_tx_restart = 1'b0;

    //            len    beats addr hbeat hcyc tx keep
    vt[0] = '{10'd32,    8,   3'd0, -1,   0,  0, 0};
    vt[1] = '{10'd1,     1,   3'd0, -1,   0,  0, 0};
    vt[2] = '{10'd32,    8,   3'd1,  3,   3,  0, 0};
    vt[3] = '{10'd20,    5,   3'd1,  0,   2,  0, 1};
    vt[4] = '{10'd16,    4,   3'd6,  2,   1,  1, 0};
    vt[5] = '{10'd5,     2,   3'd2,  1,   2,  0, 1};
    vt[6] = '{10'd0,   256,   3'd4, -1,   0,  0, 0};
    vt[7] = '{10'd3,     1,   3'd4,  0,   1,  0, 1};
    vt[8] = '{10'd1020,255,   3'd5, 100,  2,  1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", o_ram_rd_en, 1'b0);
    chk("rst_addr", 128'(o_ram_rd_addr), 128'd0);
    chk("rst_start", o_gen_tlp_start, 1'b0);
    chk("rst_data", o_rd_data, 128'd0);
    chk("rst_last", o_last_data, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_tlp(vt[i]);

    // Restart mid-stream of a 64-DW TLP, together with i_rd_en high.
    mon_en = 1'b0;
    @(negedge clk);
    i_rd_length = 10'd64;
    i_rd_en = 1'b1;
    i_mwr_tlp_tx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_restart_start", o_gen_tlp_start, 1'b1);
    i_tx_restart = 1'b1;
    @(posedge clk); #1;
    chk("rs_start", o_gen_tlp_start, 1'b0);
    chk("rs_last", o_last_data, 1'b0);
    chk("rs_data", o_rd_data, 128'd0);
    chk("rs_rd_en", o_ram_rd_en, 1'b0);
    chk("rs_addr", 128'(o_ram_rd_addr), 128'd0);
    i_tx_restart = 1'b0;
    i_rd_en = 1'b0;
    @(posedge clk); #1;
    chk("rs_idle", {o_gen_tlp_start, o_ram_rd_en}, 2'b00);
    vx = '{10'd8, 2, 3'd0, -1, 0, 0, 0};
    run_tlp(vx);

    // Reset mid-TLP: no further reads while reset is held.
    mon_en = 1'b0;
    @(negedge clk);
    i_rd_length = 10'd32;
    i_rd_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    i_rd_en = 1'b0;
    #1;
    chk("mr_start", o_gen_tlp_start, 1'b0);
    chk("mr_addr", 128'(o_ram_rd_addr), 128'd0);
    chk("mr_data", o_rd_data, 128'd0);
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_ram_rd_en || o_gen_tlp_start) bad = 1'b1;
    end
    chk("mr_quiet", bad, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vx = '{10'd8, 2, 3'd0, -1, 0, 0, 0};
    run_tlp(vx);

`ifdef PCIE_DMA_TX_RD_DBG_EN
    @(negedge clk);
    i_tx_restart = 1'b1;
    @(negedge clk);
    i_tx_restart = 1'b0;
    chk("dbg_clr", {o_dbg_tlp_cnt, o_dbg_beat_cnt}, 40'd0);
    vx = '{10'd32, 8, 3'd0, -1, 0, 0, 0};
    run_tlp(vx);
    vx = '{10'd8, 2, 3'd0, -1, 0, 0, 0};
    run_tlp(vx);
    chk("dbg_tlp", o_dbg_tlp_cnt, 16'd2);
    chk("dbg_beat", o_dbg_beat_cnt, 24'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pcie_dma_tx_ram_rd_ctrl.md
PCIE_DMA_TX_RAM_RD_CTRL -- requirements
Module: pcie_dma_tx_ram_rd_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 9, giving the 128-bit TX data RAM word-address width.
REQ-002 The block SHALL have the following ports:
- clk  in  1  (one clock; gen1 62.5 MHz, gen2 125 MHz)
- rst_n  in  1  (asynchronous, active-low)
- i_rd_en  in  1  (TLP payload read request from MWr TX control)
- i_rd_length  in  10  (payload length in DW; 0 means 1024 DW)
- i_mwr_tlp_tx  in  1  (MWr TX control is in its data phase)
- i_mwr_tx_hold  in  1  (downstream back-pressure)
- i_tx_restart  in  1  (restart pulse)
- o_ram_rd_en  out  1  (RAM read strobe)
- o_ram_rd_addr  out  ADDR_WIDTH  (RAM word address)
- i_ram_rd_data  in  128  (RAM data, valid exactly 1 cycle after o_ram_rd_en)
- o_gen_tlp_start  out  1  (payload beat available; also acts as data valid)
- o_rd_data  out  128  (current payload beat)
- o_last_data  out  1  (current beat is the final beat of the TLP)

Function
REQ-003 The block SHALL compute the beat count as (i_rd_length+3)>>2 in 11-bit arithmetic, latched on acceptance; length 0 SHALL give 256 beats.
REQ-004 The block SHALL implement states IDLE, FILL, STREAM and DONE.
REQ-005 IDLE -> FILL SHALL occur when i_rd_en=1; length and beat count SHALL be latched on that cycle.
REQ-006 In FILL the block SHALL issue RAM reads until the first beat is in the output register; it SHALL then assert o_gen_tlp_start and enter STREAM.
- First-beat latency from i_rd_en to o_gen_tlp_start SHALL be 3 cycles.
REQ-007 A beat SHALL be consumed when o_gen_tlp_start && i_mwr_tlp_tx && !i_mwr_tx_hold.
REQ-008 o_rd_data and o_last_data SHALL remain stable while o_gen_tlp_start=1 and no consume occurs.
REQ-009 The block SHALL keep a 2-entry prefetch buffer behind the output register.
- A RAM read SHALL be issued whenever unrequested beats remain and buffer space, counting in-flight reads, exists.
- The next beat SHALL appear on the cycle after each consume, so continuous consumption yields one beat per cycle without bubbles.
REQ-010 o_last_data SHALL be 1 exactly while the final beat is presented; for a 1-beat TLP it SHALL be 1 together with the first o_gen_tlp_start.
REQ-011 On consuming the final beat, o_gen_tlp_start and o_last_data SHALL deassert on the next cycle and the state SHALL go to DONE.
REQ-012 DONE -> IDLE SHALL occur only when i_rd_en=0, so a new request needs at least one low cycle of i_rd_en.
REQ-013 o_ram_rd_addr SHALL increment by 1 per read, continue contiguously across TLPs, and wrap from 2^ADDR_WIDTH-1 to 0.
REQ-014 Exactly beat-count RAM reads SHALL be issued per TLP; a prefetched but unconsumed beat SHALL never be discarded.
REQ-015 i_rd_en deasserting in FILL or STREAM SHALL be ignored until DONE.
REQ-016 i_tx_restart SHALL, in any state, return the block to IDLE, clear the buffer, clear all outputs, and set o_ram_rd_addr to 0 on the next cycle.
- i_tx_restart SHALL take priority over a simultaneous i_rd_en.

Reset
REQ-017 While rst_n=0 the block SHALL hold state IDLE, o_ram_rd_en=0, o_ram_rd_addr=0, o_gen_tlp_start=0, o_rd_data=0, o_last_data=0, and all counters and the buffer empty.
REQ-018 Reset asserted mid-TLP SHALL abort the TLP with no further RAM reads.

Configuration
REQ-019 With macro PCIE_DMA_TX_RD_DBG_EN defined, the block SHALL add output o_dbg_tlp_cnt (16 bit) and output o_dbg_beat_cnt (24 bit).
- Both SHALL increment on TLP completion and on beat consume respectively, wrap at full scale, and clear on reset and i_tx_restart.
REQ-020 Without PCIE_DMA_TX_RD_DBG_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-021 i_rd_length=32 with i_mwr_tlp_tx=1 and hold=0 -> 8 reads at addr 0..7; 8 consecutive beats equal RAM words 0..7; o_last_data on beat 8; DONE.
REQ-022 i_rd_length=1 -> one read; o_gen_tlp_start and o_last_data both 1 for one beat; next request starts at addr 1.
REQ-023 i_rd_length=32 with hold=1 for 3 cycles on beat 4 -> beat 4 data held stable 3 cycles; no beat lost or duplicated; still exactly 8 reads.
REQ-024 ADDR_WIDTH=3, start address 6, i_rd_length=16 -> addresses 6,7,0,1; data ordered accordingly.
REQ-025 i_tx_restart mid-STREAM of a 64-DW TLP -> next cycle IDLE, outputs 0, o_ram_rd_addr=0; a new request reads from addr 0.
REQ-026 With PCIE_DMA_TX_RD_DBG_EN: two TLPs of 32 and 8 DW -> o_dbg_tlp_cnt=2, o_dbg_beat_cnt=10.
